// File: rtl/data_mem.sv
// data_mem: byte-addressable data memory for the single-cycle RISC-V core.
// funct3 of the current instruction selects the access width and the load
// extension. Loads are combinational. Stores commit on the rising clock edge.
//
// Ports:
//   clk            - clock; every state update happens on its rising edge
//   reset          - synchronous, active-low; clears the whole memory
//   memAddr        - byte address; upper bits beyond the memory size are ignored
//   memReadEnable  - when low, memReadData is forced to 0
//   memReadData    - load result, zero- or sign-extended
//   memWriteEnable - store enable, sampled at the rising edge
//   memWriteData   - store data; the low byte, low half or full word is used
//   pcReadData     - current instruction word; funct3 = pcReadData[14:12]
module data_mem #(
  parameter int unsigned WORD_ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddr,
  input  logic        memReadEnable,
  output logic [31:0] memReadData,
  input  logic        memWriteEnable,
  input  logic [31:0] memWriteData,
  input  logic [31:0] pcReadData
);

  localparam int unsigned DEPTH = 1 << WORD_ADDR_BITS;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_t;

  logic [31:0]               mem [DEPTH];
  logic [WORD_ADDR_BITS-1:0] word_idx;
  logic [2:0]                funct3;
  size_t                     size;
  logic                      is_unsigned;
  logic [3:0]                byte_en;
  logic [31:0]               wr_word;
  logic [31:0]               rd_word;
  logic [31:0]               rd_shifted;

  // Address bits above the memory size and non-funct3 instruction bits
  // are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{memAddr[31:WORD_ADDR_BITS+2], pcReadData[31:15],
                         pcReadData[11:0]};

  assign word_idx    = memAddr[WORD_ADDR_BITS+1:2];
  assign funct3      = pcReadData[14:12];
  assign is_unsigned = funct3[2];

  always_comb begin
    size = SIZE_WORD;
    case (funct3)
      3'b000, 3'b100: size = SIZE_BYTE;
      3'b001, 3'b101: size = SIZE_HALF;
      default:        size = SIZE_WORD;
    endcase
  end

  // Store data is replicated across all lanes so each byte enable can pick
  // its own lane without a shifter.
  always_comb begin
    byte_en = '0;
    wr_word = memWriteData;
    case (size)
      SIZE_BYTE: begin
        byte_en[memAddr[1:0]] = 1'b1;
        wr_word = {4{memWriteData[7:0]}};
      end
      SIZE_HALF: begin
        byte_en = memAddr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{memWriteData[15:0]}};
      end
      default: begin
        byte_en = '1;
        wr_word = memWriteData;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (memWriteEnable) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
        end
      end
    end
  end

  assign rd_word = mem[word_idx];

  always_comb begin
    rd_shifted  = '0;
    memReadData = '0;
    if (memReadEnable) begin
      case (size)
        SIZE_BYTE: begin
          rd_shifted  = rd_word >> {memAddr[1:0], 3'b000};
          memReadData = {{24{rd_shifted[7] & ~is_unsigned}}, rd_shifted[7:0]};
        end
        SIZE_HALF: begin
          rd_shifted  = memAddr[1] ? {16'h0000, rd_word[31:16]} : rd_word;
          memReadData = {{16{rd_shifted[15] & ~is_unsigned}}, rd_shifted[15:0]};
        end
        default: memReadData = rd_word;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memAddr;
  logic        memReadEnable;
  logic [31:0] memReadData;
  logic        memWriteEnable;
  logic [31:0] memWriteData;
  logic [31:0] pcReadData;

  int unsigned checks = 0;
  int unsigned failures = 0;

  data_mem #(.WORD_ADDR_BITS(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .memAddr       (memAddr),
    .memReadEnable (memReadEnable),
    .memReadData   (memReadData),
    .memWriteEnable(memWriteEnable),
    .memWriteData  (memWriteData),
    .pcReadData    (pcReadData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] insn(input logic [2:0] f3);
    return {17'b0, f3, 12'b0};
  endfunction

  task automatic write_op(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    @(negedge clk);
    memAddr        = addr;
    memWriteData   = data;
    pcReadData     = insn(f3);
    memWriteEnable = 1'b1;
    @(posedge clk);
    #1;
    memWriteEnable = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] exp);
    memAddr       = addr;
    pcReadData    = insn(f3);
    memReadEnable = 1'b1;
    #1;
    check(tag, memReadData, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [31:0] last_byte;
  logic        we_now;

  initial begin
    reset          = 1'b0;
    memAddr        = '0;
    memReadEnable  = 1'b0;
    memWriteEnable = 1'b0;
    memWriteData   = '0;
    pcReadData     = '0;

    // Reset
    @(posedge clk);
    do_reset();
    read_chk("reset_word_200", 32'h200, 3'b010, 32'h0);
    memReadEnable = 1'b0;
    #1;
    check("reset_rd_disabled", memReadData, 32'h0);

    // Byte store sequence: data changes every half period, enable toggles every 20 cycles
    memAddr       = 32'h200;
    pcReadData    = insn(3'b000);
    memReadEnable = 1'b1;
    last_byte     = 32'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      we_now         = ((c / 20) % 2) == 0;
      memWriteData   = 32'h0000_0070 + 32'(2 * c);
      memWriteEnable = we_now;
      if (we_now) last_byte = memWriteData;
      @(posedge clk);
      #1;
      if (c == 5) check("seq_mid_lb", memReadData, 32'h0000_007A);
      #1;
      memWriteData = 32'h0000_0070 + 32'(2 * c + 1);
    end
    memWriteEnable = 1'b0;
    // last enabled edge is c=19 -> 0x70 + 38 = 0x96
    check("seq_last_byte_model", last_byte, 32'h0000_0096);
    read_chk("seq_lb_200", 32'h200, 3'b000, 32'hFFFF_FF96);
    read_chk("seq_lbu_200", 32'h200, 3'b100, 32'h0000_0096);
    read_chk("seq_lbu_201", 32'h201, 3'b100, 32'h0);
    read_chk("seq_lbu_202", 32'h202, 3'b100, 32'h0);
    read_chk("seq_lbu_203", 32'h203, 3'b100, 32'h0);

    // Sign vs zero extension, from a cleared memory
    do_reset();
    read_chk("rst_clears_200", 32'h200, 3'b100, 32'h0);
    write_op(32'h201, 32'h0000_00F0, 3'b000);
    read_chk("lb_201", 32'h201, 3'b000, 32'hFFFF_FFF0);
    read_chk("lbu_201", 32'h201, 3'b100, 32'h0000_00F0);
    read_chk("lw_200_after_sb", 32'h200, 3'b010, 32'h0000_F000);

    // Halfword
    write_op(32'h206, 32'h1234_ABCD, 3'b001);
    read_chk("lw_204_after_sh", 32'h204, 3'b010, 32'hABCD_0000);
    read_chk("lh_206", 32'h206, 3'b001, 32'hFFFF_ABCD);
    read_chk("lhu_206", 32'h206, 3'b101, 32'h0000_ABCD);
    read_chk("lh_207_bit0_ignored", 32'h207, 3'b001, 32'hFFFF_ABCD);
    read_chk("lh_204_low_half", 32'h204, 3'b001, 32'h0);

    // Word store with address wrap
    write_op(32'h1000, 32'hDEAD_BEEF, 3'b010);
    read_chk("lw_000_wrap", 32'h000, 3'b010, 32'hDEAD_BEEF);
    read_chk("f3_011_as_word", 32'h003, 3'b011, 32'hDEAD_BEEF);
    read_chk("f3_111_as_word", 32'h000, 3'b111, 32'hDEAD_BEEF);
    read_chk("lb_003", 32'h003, 3'b000, 32'hFFFF_FFDE);
    read_chk("lhu_002", 32'h002, 3'b101, 32'h0000_DEAD);
    read_chk("lbu_001", 32'h001, 3'b100, 32'h0000_00BE);

    // Read and write together: old data before the edge, new data after
    memAddr = 32'h000;
    pcReadData = insn(3'b010);
    @(negedge clk);
    memWriteData   = 32'h0BAD_F00D;
    memWriteEnable = 1'b1;
    #1;
    check("rw_pre_edge", memReadData, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    memWriteEnable = 1'b0;
    check("rw_post_edge", memReadData, 32'h0BAD_F00D);

    // Read disable
    memReadEnable = 1'b0;
    #1;
    check("rd_disabled", memReadData, 32'h0);

    // Reset overrides a concurrent write
    @(negedge clk);
    reset          = 1'b0;
    memAddr        = 32'h300;
    memWriteData   = 32'h1122_3344;
    pcReadData     = insn(3'b010);
    memWriteEnable = 1'b1;
    @(posedge clk);
    #1;
    reset          = 1'b1;
    memWriteEnable = 1'b0;
    read_chk("reset_over_write_300", 32'h300, 3'b010, 32'h0);
    read_chk("reset_lost_000", 32'h000, 3'b010, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
